retire_trace_buffer: RTL and testbench
======================================

Name: retire_trace_buffer

Overview:
Synthesizable successor to the simulation-only retire monitor. Observes per-cycle writeback and memory-stage events of the pipelined CPU and maintains cycle, retired-instruction and dropped-record counters. Enforces a cycle-limit watchdog and stores one timestamped trace record per active cycle in a parametrised FIFO. A debug reader drains the FIFO over a valid/ready port, so traces survive on hardware without $fdisplay.

Parameters:
DATA_W, 16, register/memory data width
ADDR_W, 16, PC and memory address width
REG_W, 4, register-index width
DEPTH, 16, FIFO entries; power of two, >= 2
CYC_W, 32, cycle/instruction counter width
MAX_CYCLES, 100000, watchdog limit in RUN cycles

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
pc  in  ADDR_W  PC of the observed cycle
reg_write  in  1  register file written this cycle
write_reg  in  REG_W  destination register
write_data  in  DATA_W  data written to the register
mem_read  in  1  data-memory read this cycle
mem_write  in  1  data-memory write this cycle
mem_addr  in  ADDR_W  data-memory address
mem_wdata  in  DATA_W  data written to memory
mem_rdata  in  DATA_W  data read from memory
hlt  in  1  halt in memory/writeback stage
trc_ready  in  1  reader accepts the head record
trc_valid  out  1  head record valid
trc_cycle  out  CYC_W  record timestamp
trc_pc  out  ADDR_W  record PC
trc_flags  out  4  {hlt, mem_write, mem_read, reg_write}
trc_reg  out  REG_W  record write_reg
trc_wdata  out  DATA_W  record write_data
trc_maddr  out  ADDR_W  record mem_addr
trc_mdata  out  DATA_W  mem_wdata if mem_write, else mem_rdata
cycle_count  out  CYC_W  RUN cycles elapsed
inst_count  out  CYC_W  retired instructions
drop_count  out  16  records lost to overflow, saturating
overflow  out  1  sticky: at least one record dropped
halted  out  1  state is HALTED
timeout  out  1  state is TIMEOUT

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-low on rst_n. A low rst_n at a rising edge resets everything; no asynchronous paths.
- Reset values: every output 0; FIFO empty; state RUN.
- States: RUN, HALTED, TIMEOUT. HALTED and TIMEOUT are terminal and are left only by reset.
- RUN, every cycle:
  - cycle_count += 1.
  - event = reg_write | mem_read | mem_write | hlt.
  - inst_count += 1 if hlt | reg_write | mem_write.
  - If event, push a record stamped with the pre-increment cycle_count (first RUN cycle stamps 0).
- Transitions:
  - hlt in RUN -> HALTED next cycle; the halt record is still pushed and counted.
  - cycle_count == MAX_CYCLES-1 with no hlt -> TIMEOUT next cycle.
  - hlt and the limit in the same cycle -> HALTED (halt wins).
- HALTED/TIMEOUT: counters frozen; no pushes; inputs ignored; FIFO drain continues.
- FIFO:
  - Pop occurs when trc_valid & trc_ready.
  - A push is accepted when not full, or when full and a pop occurs in the same cycle.
  - No fall-through: a record pushed into an empty FIFO shows trc_valid the next cycle.
  - trc_* outputs hold stable while trc_valid=1 and trc_ready=0.
  - Pointers wrap modulo DEPTH; full/empty come from an extra pointer bit.
- Overflow: a rejected push sets overflow (sticky) and increments drop_count, saturating at 16'hFFFF. inst_count still counts the instruction.
- Counter wrap: cycle_count and inst_count wrap modulo 2^CYC_W. With defaults, the watchdog fires first.
- Reset mid-drain: FIFO contents are discarded and trc_valid=0 the cycle after the reset edge.

Decomposition:
- Package trace_pkg:
  - state enum {RUN, HALTED, TIMEOUT}
  - flag bit positions (REG=0, MRD=1, MWR=2, HLT=3)
  - packed trace record struct, parametrised by the widths
  - DROP_W=16
- Sub-module trace_fifo: synchronous, DEPTH entries of the packed record, push/pop/full/empty. The top level holds the FSM, counters, record packing and overflow accounting.

Test Plan:
- Reset, then reg_write=1, write_reg=3, write_data=16'h00A5, pc=16'h0002 in the first RUN cycle, trc_ready=1 -> next cycle trc_valid=1, trc_cycle=0, trc_flags=4'b0001, trc_reg=3, trc_wdata=16'h00A5; inst_count=1.
- mem_write=1, mem_addr=16'h0040, mem_wdata=16'h1234, then mem_read=1, mem_rdata=16'hBEEF -> two records, flags 4'b0100 with mdata=16'h1234, then 4'b0010 with mdata=16'hBEEF; inst_count +1 only for the store.
- trc_ready=0, 20 consecutive reg_write cycles with DEPTH=16 -> 16 records kept, overflow=1, drop_count=4. Then trc_ready=1 for one cycle with a push -> push accepted, drop_count stays 4.
- hlt=1 at RUN cycle 10 -> halt record trc_cycle=10 with flag bit 3 set; halted=1 next cycle; cycle_count frozen at 11; later reg_write ignored.
- MAX_CYCLES=8 with no hlt -> timeout=1 after cycle 7, cycle_count=8. Repeat with hlt at cycle 7 -> halted=1, timeout=0.
- FIFO holding 5 records, rst_n=0 for one edge -> trc_valid=0, all counters 0, overflow cleared, state RUN.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and constants for the retire trace buffer: run-state
// encoding, trace flag bit positions and the drop counter width.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    // Bit positions inside the 4-bit trace flag field.
    localparam int FLAG_REG = 0;
    localparam int FLAG_MRD = 1;
    localparam int FLAG_MWR = 2;
    localparam int FLAG_HLT = 3;
    localparam int FLAG_W   = 4;

    // Width of the saturating dropped-record counter.
    localparam int DROP_W = 16;

    // Total width of one packed trace record for a given set of widths.
    // Field order: cycle, pc, flags, reg, wdata, maddr, mdata.
    function automatic int rec_width(input int cyc_w, input int addr_w,
                                     input int reg_w, input int data_w);
        return cyc_w + addr_w + FLAG_W + reg_w + data_w + addr_w + data_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding packed trace records. The head entry is read
// combinationally from storage, so a record becomes visible the cycle after
// it is written (no fall-through) and stays put until it is popped.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             accepted
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop_fire;
    logic             push_fire;

    // The extra pointer MSB separates the full and empty cases when the
    // index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop_fire  = pop & ~empty;
    assign push_fire = push & (~full | pop_fire);
    assign accepted  = push_fire;

    assign dout = mem[rd_ptr[AW-1:0]];

    // Pointer update; pointers wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_fire)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Record storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; resetting the pointers
        // already makes stale entries unreachable, and an unreset array maps
        // onto plain RAM.
        if (push_fire) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: watches writeback/memory-stage events, keeps cycle,
// retired-instruction and dropped-record counters, enforces a cycle-limit
// watchdog and queues one timestamped record per active cycle for a
// valid/ready debug reader.
module retire_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int REG_W      = 4,
    parameter int DEPTH      = 16,
    parameter int CYC_W      = 32,
    parameter int MAX_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic              reg_write,
    input  logic [REG_W-1:0]  write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              hlt,
    input  logic              trc_ready,
    output logic              trc_valid,
    output logic [CYC_W-1:0]  trc_cycle,
    output logic [ADDR_W-1:0] trc_pc,
    output logic [3:0]        trc_flags,
    output logic [REG_W-1:0]  trc_reg,
    output logic [DATA_W-1:0] trc_wdata,
    output logic [ADDR_W-1:0] trc_maddr,
    output logic [DATA_W-1:0] trc_mdata,
    output logic [CYC_W-1:0]  cycle_count,
    output logic [CYC_W-1:0]  inst_count,
    output logic [15:0]       drop_count,
    output logic              overflow,
    output logic              halted,
    output logic              timeout
);

    typedef struct packed {
        logic [CYC_W-1:0]  cycle;
        logic [ADDR_W-1:0] pc;
        logic [FLAG_W-1:0] flags;
        logic [REG_W-1:0]  rreg;
        logic [DATA_W-1:0] wdata;
        logic [ADDR_W-1:0] maddr;
        logic [DATA_W-1:0] mdata;
    } rec_t;

    localparam int REC_W = rec_width(CYC_W, ADDR_W, REG_W, DATA_W);
    localparam logic [CYC_W-1:0] LIMIT = CYC_W'(MAX_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    rec_t              rec_in;
    rec_t              rec_out;
    logic [REC_W-1:0]  fifo_dout;
    logic              running;
    logic              trace_event;
    logic              retire;
    logic              push;
    logic              accepted;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DROP_W-1:0] drops;

    assign running     = (state == ST_RUN);
    assign trace_event = reg_write | mem_read | mem_write | hlt;
    assign retire      = hlt | reg_write | mem_write;
    assign push        = running & trace_event;

    // Pack the current cycle's event, stamped with the pre-increment count.
    always_comb begin
        rec_in                 = '0;
        rec_in.cycle           = cycle_count;
        rec_in.pc              = pc;
        rec_in.flags[FLAG_REG] = reg_write;
        rec_in.flags[FLAG_MRD] = mem_read;
        rec_in.flags[FLAG_MWR] = mem_write;
        rec_in.flags[FLAG_HLT] = hlt;
        rec_in.rreg            = write_reg;
        rec_in.wdata           = write_data;
        rec_in.maddr           = mem_addr;
        rec_in.mdata           = mem_write ? mem_wdata : mem_rdata;
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (trc_ready),
        .din      (rec_in),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .accepted (accepted)
    );

    // Run-state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_next;
    end

    // Next state: halt beats the watchdog; both terminal states hold.
    always_comb begin
        // NOTE: assigning a default before any branch keeps every path
        // driven, so no latch is inferred.
        state_next = state;
        if (state == ST_RUN) begin
            if (hlt)                       state_next = ST_HALTED;
            else if (cycle_count == LIMIT) state_next = ST_TIMEOUT;
        end
    end

    // Cycle/instruction counters advance only in RUN and wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_count <= '0;
            inst_count  <= '0;
        end else if (running) begin
            cycle_count <= cycle_count + CYC_W'(1);
            if (retire) inst_count <= inst_count + CYC_W'(1);
        end
    end

    // Overflow accounting: a rejected push is lost and counted, saturating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drops    <= '0;
            overflow <= 1'b0;
        end else if (push && !accepted) begin
            overflow <= 1'b1;
            if (drops != '1) drops <= drops + DROP_W'(1);
        end
    end

    // Head record is forced to zero while the FIFO is empty so the trace
    // outputs read as zero out of reset.
    assign rec_out    = fifo_empty ? '0 : rec_t'(fifo_dout);
    assign trc_valid  = ~fifo_empty;
    assign trc_cycle  = rec_out.cycle;
    assign trc_pc     = rec_out.pc;
    assign trc_flags  = rec_out.flags;
    assign trc_reg    = rec_out.rreg;
    assign trc_wdata  = rec_out.wdata;
    assign trc_maddr  = rec_out.maddr;
    assign trc_mdata  = rec_out.mdata;
    assign drop_count = drops;
    assign halted     = (state == ST_HALTED);
    assign timeout    = (state == ST_TIMEOUT);

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: a default-parameter instance for
// record content, overflow, halt and reset, and a MAX_CYCLES=8 instance for
// the watchdog and halt-versus-limit priority.
module tb_retire_trace_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- main instance (default parameters) ----------------
    logic        rst_n, reg_write, mem_read, mem_write, hlt, trc_ready;
    logic [15:0] pc, write_data, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  write_reg;
    logic        trc_valid, overflow, halted, timeout;
    logic [31:0] trc_cycle, cycle_count, inst_count;
    logic [15:0] trc_pc, trc_wdata, trc_maddr, trc_mdata, drop_count;
    logic [3:0]  trc_flags, trc_reg;

    retire_trace_buffer dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .reg_write(reg_write),
        .write_reg(write_reg), .write_data(write_data), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .hlt(hlt), .trc_ready(trc_ready),
        .trc_valid(trc_valid), .trc_cycle(trc_cycle), .trc_pc(trc_pc),
        .trc_flags(trc_flags), .trc_reg(trc_reg), .trc_wdata(trc_wdata),
        .trc_maddr(trc_maddr), .trc_mdata(trc_mdata),
        .cycle_count(cycle_count), .inst_count(inst_count),
        .drop_count(drop_count), .overflow(overflow), .halted(halted),
        .timeout(timeout)
    );

    // ---------------- watchdog instance (MAX_CYCLES = 8) ----------------
    logic        b_rst_n, b_hlt;
    logic        b_zero1 = 1'b0;
    logic [15:0] b_zero16 = '0;
    logic [3:0]  b_zero4 = '0;
    logic        b_valid, b_overflow, b_halted, b_timeout;
    logic [31:0] b_tcycle, b_cycle_count, b_inst_count;
    logic [15:0] b_pc, b_wdata, b_maddr, b_mdata, b_drop;
    logic [3:0]  b_flags, b_reg;

    retire_trace_buffer #(.MAX_CYCLES(8)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .pc(b_zero16), .reg_write(b_zero1),
        .write_reg(b_zero4), .write_data(b_zero16), .mem_read(b_zero1),
        .mem_write(b_zero1), .mem_addr(b_zero16), .mem_wdata(b_zero16),
        .mem_rdata(b_zero16), .hlt(b_hlt), .trc_ready(b_zero1),
        .trc_valid(b_valid), .trc_cycle(b_tcycle), .trc_pc(b_pc),
        .trc_flags(b_flags), .trc_reg(b_reg), .trc_wdata(b_wdata),
        .trc_maddr(b_maddr), .trc_mdata(b_mdata),
        .cycle_count(b_cycle_count), .inst_count(b_inst_count),
        .drop_count(b_drop), .overflow(b_overflow), .halted(b_halted),
        .timeout(b_timeout)
    );

    // Advance one rising edge; inputs and checks happen 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_write = 0; mem_read = 0; mem_write = 0; hlt = 0;
        pc = '0; write_reg = '0; write_data = '0;
        mem_addr = '0; mem_wdata = '0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    initial begin
        idle();
        trc_ready = 1;
        b_hlt = 0;
        b_rst_n = 0;
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;

        // Reset state.
        check("rst_valid", trc_valid, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_inst_count", inst_count, 0);
        check("rst_drop", drop_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_halted", halted, 0);
        check("rst_timeout", timeout, 0);
        check("rst_trc_pc", trc_pc, 0);

        // First RUN cycle: register write.
        reg_write = 1; write_reg = 4'd3; write_data = 16'h00A5; pc = 16'h0002;
        tick();
        idle();
        check("rw_valid", trc_valid, 1);
        check("rw_cycle", trc_cycle, 0);
        check("rw_flags", trc_flags, 4'b0001);
        check("rw_reg", trc_reg, 3);
        check("rw_wdata", trc_wdata, 16'h00A5);
        check("rw_pc", trc_pc, 16'h0002);
        check("rw_inst", inst_count, 1);

        // Store then load; ready=1 pops the previous head each cycle.
        mem_write = 1; mem_addr = 16'h0040; mem_wdata = 16'h1234;
        tick();
        idle();
        check("st_flags", trc_flags, 4'b0100);
        check("st_mdata", trc_mdata, 16'h1234);
        check("st_maddr", trc_maddr, 16'h0040);
        check("st_cycle", trc_cycle, 1);
        check("st_inst", inst_count, 2);
        mem_read = 1; mem_addr = 16'h0040; mem_rdata = 16'hBEEF;
        tick();
        idle();
        check("ld_flags", trc_flags, 4'b0010);
        check("ld_mdata", trc_mdata, 16'hBEEF);
        check("ld_cycle", trc_cycle, 2);
        check("ld_inst", inst_count, 2);
        tick();
        check("drain_empty", trc_valid, 0);
        check("drain_cycles", cycle_count, 4);

        // Overflow: 20 register writes with the reader stalled.
        trc_ready = 0;
        for (int i = 0; i < 20; i++) begin
            reg_write = 1; write_reg = 4'(i); write_data = 16'(i);
            tick();
        end
        check("ovf_flag", overflow, 1);
        check("ovf_drop", drop_count, 4);
        check("ovf_inst", inst_count, 22);
        check("ovf_head_cycle", trc_cycle, 4);
        check("ovf_head_stable", trc_wdata, 0);
        // Full FIFO with a simultaneous pop takes the push.
        trc_ready = 1;
        tick();
        idle();
        check("ovf_pushpop_drop", drop_count, 4);
        check("ovf_pushpop_head", trc_cycle, 5);
        check("ovf_pushpop_inst", inst_count, 23);
        for (int i = 0; i < 16; i++) tick();
        check("ovf_drained", trc_valid, 0);
        check("ovf_cycles", cycle_count, 41);

        // Halt at RUN cycle 10.
        do_reset();
        trc_ready = 0;
        for (int i = 0; i < 10; i++) tick();
        hlt = 1; pc = 16'h0014;
        tick();
        idle();
        check("hlt_halted", halted, 1);
        check("hlt_cycle_count", cycle_count, 11);
        check("hlt_rec_cycle", trc_cycle, 10);
        check("hlt_rec_flags", trc_flags, 4'b1000);
        check("hlt_inst", inst_count, 1);
        reg_write = 1; write_data = 16'hFFFF;
        for (int i = 0; i < 3; i++) tick();
        idle();
        check("hlt_frozen_cycles", cycle_count, 11);
        check("hlt_frozen_inst", inst_count, 1);
        check("hlt_no_push_head", trc_flags, 4'b1000);
        trc_ready = 1;
        tick();
        check("hlt_drain", trc_valid, 0);
        check("hlt_still_halted", halted, 1);

        // Reset mid-drain with 5 records queued and overflow set.
        do_reset();
        trc_ready = 0;
        reg_write = 1;
        for (int i = 0; i < 18; i++) tick();
        idle();
        trc_ready = 1;
        for (int i = 0; i < 11; i++) tick();
        trc_ready = 0;
        check("pre_rst_valid", trc_valid, 1);
        check("pre_rst_head", trc_cycle, 11);
        check("pre_rst_overflow", overflow, 1);
        rst_n = 0;
        tick();
        rst_n = 1;
        check("mid_rst_valid", trc_valid, 0);
        check("mid_rst_cycles", cycle_count, 0);
        check("mid_rst_inst", inst_count, 0);
        check("mid_rst_drop", drop_count, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_halted", halted, 0);
        tick();
        check("mid_rst_run", cycle_count, 1);

        // Watchdog with MAX_CYCLES=8.
        b_rst_n = 1;
        for (int i = 0; i < 7; i++) tick();
        check("wd_before", b_timeout, 0);
        check("wd_before_cc", b_cycle_count, 7);
        tick();
        check("wd_timeout", b_timeout, 1);
        check("wd_cc", b_cycle_count, 8);
        tick();
        check("wd_frozen", b_cycle_count, 8);

        // Halt coinciding with the limit: halt wins.
        b_rst_n = 0;
        tick();
        b_rst_n = 1;
        for (int i = 0; i < 7; i++) tick();
        b_hlt = 1;
        tick();
        b_hlt = 0;
        check("wdh_halted", b_halted, 1);
        check("wdh_timeout", b_timeout, 0);
        check("wdh_cc", b_cycle_count, 8);
        check("wdh_rec_cycle", b_tcycle, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
